// File: rtl/mem_phase_port_pkg.sv
// Shared types and constants for the two-phase memory port.
package mem_phase_port_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_WAIT = 2'd1,
        DATA_WAIT  = 2'd2
    } mport_state_t;

    // Instruction word loaded into ir on reset or an aborted fetch.
    localparam int unsigned NOP = 0;

endpackage

// File: rtl/mem_phase_port_wait_timer.sv
// Wait-state counter: cleared while idle, counts wait cycles, flags the last allowed one.
module wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Saturates so a stuck enable can never wrap back to an early expire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expire = en & (count == LAST);

endmodule

// File: rtl/mem_phase_port.sv
// Memory-side responder for the two-phase sequencer: one req/ack access per INSTR or DATA phase.
module mem_phase_port
    import mem_phase_port_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_phase,
    input  logic [ADDR_W-1:0] pc,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP);

    mport_state_t state;
    mport_state_t state_next;
    logic         timer_hit;
    logic         expire;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .en     (state != IDLE),
        .expire (timer_hit)
    );

    // An ack arriving on the final wait cycle takes priority over the abort.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                stall = instr_phase | dreq;
                if (instr_phase) begin
                    state_next = FETCH_WAIT;
                end else if (dreq) begin
                    state_next = DATA_WAIT;
                end
            end
            FETCH_WAIT, DATA_WAIT: begin
                expire = timer_hit & ~mem_ack;
                stall  = ~mem_ack & ~expire;
                if (mem_ack || expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ir        <= NOP_WORD;
            rdata     <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (instr_phase) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (dreq) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dwe;
                        mem_addr  <= daddr;
                        mem_wdata <= dwdata;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_ack) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                    end else if (expire) begin
                        ir      <= NOP_WORD;
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                    end
                end
                DATA_WAIT: begin
                    // Stores never touch rdata, whether they complete or abort.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                    end else if (expire) begin
                        if (!mem_we) begin
                            rdata <= '0;
                        end
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                    end
                end
                default: mem_req <= 1'b0;
            endcase
        end
    end

endmodule
